bottle_setup_ctrl: RTL and testbench
====================================

Name: bottle_setup_ctrl

Overview:
Operator-facing front end of the bottle-filling counter. It debounces four push-buttons and holds the per-bottle pill limit and the bottle-count limit as two-digit BCD values. A mode FSM drives the counter stage directly downstream through its control and limit inputs (isWork, EN_work, EN_set, set, maxL/maxH, bot_maxL/bot_maxH), and consumes that stage's allFull.

Parameters:
DEB_CYCLES, 250000, cycles a synchronised button must be stable before its level is accepted (20 in simulation).
PILL_DEF, 8'h12, reset pill limit, packed BCD {H,L}.
BOT_DEF, 8'h05, reset bottle limit, packed BCD {H,L}.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
btn_mode  in  1  raw button, asynchronous, active-high.
btn_up  in  1  raw button, asynchronous, active-high.
btn_down  in  1  raw button, asynchronous, active-high.
btn_start  in  1  raw button, asynchronous, active-high.
allFull  in  1  batch-complete flag from the counter stage.
maxL / maxH  out  4 each  pill limit, BCD units/tens.
bot_maxL / bot_maxH  out  4 each  bottle limit, BCD units/tens.
isWork  out  1  counter enabled.
EN_work  out  1  counter control.
EN_set  out  1  counter control.
set  out  1  counter control; low together with EN_work=EN_set=1 clears the counter.
state_o  out  3  FSM state code, for display.
edit_blink  out  1  high in SET_PILL/SET_BOT, for digit blinking.

Behaviour:
- Input conditioning: each button passes a 2-FF synchroniser, then a debounce counter, then a rising-edge detector. The result is a 1-cycle pulse. Latency from a stable raw edge to the pulse is DEB_CYCLES+3 cycles. Holding a button gives exactly one pulse (no auto-repeat).
- Pulse priority when several pulses land in one cycle: mode > start > up > down. Only the highest-priority pulse acts; the rest are dropped.
- FSM states and codes: IDLE=0, SET_PILL=1, SET_BOT=2, CLEAR=3, RUN=4, PAUSE=5, DONE=6.
  - IDLE: mode -> SET_PILL; start -> CLEAR.
  - SET_PILL: up/down edit the pill limit; mode -> SET_BOT; start is ignored.
  - SET_BOT: up/down edit the bottle limit; mode -> IDLE; start is ignored.
  - CLEAR: always exactly one cycle, then -> RUN.
  - RUN: allFull=1 -> DONE (takes precedence over start); start -> PAUSE; mode, up and down are ignored.
  - PAUSE: start -> RUN; mode -> IDLE (abort).
  - DONE: start -> CLEAR (new batch); mode -> IDLE.
- Output decode per state, given as isWork/EN_work/EN_set/set:
  - IDLE: 0/0/0/1
  - SET_*: 0/0/1/1
  - CLEAR: 0/1/1/0
  - RUN: 1/0/0/1
  - PAUSE: 1/1/0/1 (counting frozen, counts held)
  - DONE: 1/0/0/1 (isWork is held so allFull stays latched downstream)
- All outputs are registered.
- Limit arithmetic:
  - Each limit is a 2-digit BCD value in the range 01..99.
  - Values whose units digit is 0 are illegal, because the counter stage terminates on units == limitL-1. up/down skip them: 09 up -> 11, 11 down -> 09.
  - Wrap-around: 99 up -> 01; 01 down -> 99.
  - Digits never leave 0..9. Tens carry and borrow are handled in BCD.
- Limits are frozen outside the SET_* states.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE.
  - maxH/maxL = PILL_DEF, bot_maxH/bot_maxL = BOT_DEF.
  - isWork=0, EN_work=0, EN_set=0, set=1, edit_blink=0.
  - Debounce and synchroniser state cleared.
- A raw edge shorter than DEB_CYCLES produces no pulse.

Decomposition:
- Package bottle_pkg:
  - state enum/localparams (3-bit codes above).
  - BCD digit type (4-bit).
  - PILL_DEF and BOT_DEF defaults.
  - Helper functions bcd2_inc_skip0 and bcd2_dec_skip0.
- Sub-module btn_conditioner (parameter DEB_CYCLES; ports CLK, RST_N, raw, pulse), instantiated four times.

Test Plan:
1. Reset with no buttons pressed -> maxH/maxL = 1/2, bot_maxH/bot_maxL = 0/5, state_o=0, set=1, isWork=0.
2. mode, then up x8 -> pill limit 12 -> 13 ... 19 -> 21 (20 skipped). Then down x1 -> 19.
3. Editing the pill limit:
   - In SET_PILL, starting from 01: down -> 99; up -> 01.
   - Editing the bottle limit from SET_BOT, starting at 05: up x5 -> 11.
4. IDLE, start -> exactly one cycle of EN_work=EN_set=1, set=0, then RUN (isWork=1, EN_*=0). Next start -> PAUSE (EN_work=1). Next start -> RUN.
5. In RUN, raise allFull -> DONE next cycle with isWork still 1. Then mode -> IDLE, isWork=0.
6. Input filtering:
   - 10-cycle glitch on btn_up (DEB_CYCLES=20) -> no change.
   - mode and up pulses in the same cycle in SET_PILL -> SET_BOT, limit unchanged.
   - RST_N low mid-RUN -> immediate reset values.

Source files
------------

// File: rtl/bottle_pkg.sv
// Shared types, defaults and BCD helpers for the bottle-filling setup front end.
//   state_e  : 3-bit mode FSM state codes (also shown on the display)
//   bcd_t    : one BCD digit
//   bcd2_t   : two-digit packed BCD value {h, l}
//   bcd2_inc_skip0 / bcd2_dec_skip0 : limit stepping over 01..99, skipping x0
package bottle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_PILL = 3'd1,
        ST_SET_BOT  = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_RUN      = 3'd4,
        ST_PAUSE    = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t h;
        bcd_t l;
    } bcd2_t;

    localparam logic [7:0] PILL_DEF = 8'h12;
    localparam logic [7:0] BOT_DEF  = 8'h05;

    // Units digit 0 is never produced: the counter stage ends a bottle on
    // units == limitL-1, which has no meaning for limitL == 0.
    function automatic bcd2_t bcd2_inc_skip0(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.l >= 4'd9) begin
            r.l = 4'd1;
            r.h = (v.h >= 4'd9) ? 4'd0 : v.h + 4'd1;   // 99 -> 01
        end else begin
            r.l = v.l + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd2_t bcd2_dec_skip0(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.l <= 4'd1) begin
            r.l = 4'd9;
            r.h = (v.h == 4'd0) ? 4'd9 : v.h - 4'd1;   // 01 -> 99
        end else begin
            r.l = v.l - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter, rising-edge
// detector. Emits one 1-cycle pulse DEB_CYCLES+3 cycles after a raw rising
// edge that stays stable; holding the button never repeats.
//   CLK   : clock
//   RST_N : async active-low reset
//   raw   : asynchronous raw button level, active-high
//   pulse : registered 1-cycle press pulse
module btn_conditioner #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic pulse
);
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic          s1_q, s2_q;
    logic          deb_q, deb_prev_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
            pulse_q    <= 1'b0;
        end else begin
            s1_q       <= raw;
            s2_q       <= s1_q;
            deb_prev_q <= deb_q;
            pulse_q    <= deb_q & ~deb_prev_q;
            // Any return to the accepted level restarts the stability window,
            // so a glitch shorter than DEB_CYCLES is discarded.
            if (s2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                cnt_q <= '0;
                deb_q <= s2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/bottle_setup_ctrl.sv
// Operator front end of the bottle-filling counter. Debounces four buttons,
// holds the pill and bottle limits as 2-digit BCD, and runs the mode FSM that
// drives the downstream counter stage.
//   CLK, RST_N               : clock, async active-low reset
//   btn_mode/up/down/start   : raw buttons
//   allFull                  : batch-complete flag from the counter stage
//   maxH/maxL                : pill limit (BCD tens/units)
//   bot_maxH/bot_maxL        : bottle limit (BCD tens/units)
//   isWork/EN_work/EN_set/set: counter stage controls
//   state_o                  : FSM state code for display
//   edit_blink               : high while a limit is being edited
module bottle_setup_ctrl
    import bottle_pkg::*;
#(
    parameter int         DEB_CYCLES = 250000,
    parameter logic [7:0] PILL_INIT  = PILL_DEF,
    parameter logic [7:0] BOT_INIT   = BOT_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start,
    input  logic       allFull,
    output logic [3:0] maxL,
    output logic [3:0] maxH,
    output logic [3:0] bot_maxL,
    output logic [3:0] bot_maxH,
    output logic       isWork,
    output logic       EN_work,
    output logic       EN_set,
    output logic       set,
    output logic [2:0] state_o,
    output logic       edit_blink
);
    logic p_mode, p_up, p_down, p_start;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_mode  (.CLK(CLK), .RST_N(RST_N), .raw(btn_mode),  .pulse(p_mode));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_up    (.CLK(CLK), .RST_N(RST_N), .raw(btn_up),    .pulse(p_up));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_down  (.CLK(CLK), .RST_N(RST_N), .raw(btn_down),  .pulse(p_down));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_start (.CLK(CLK), .RST_N(RST_N), .raw(btn_start), .pulse(p_start));

    // Only the highest-priority pulse of a cycle acts: mode > start > up > down.
    logic act_mode, act_start, act_up, act_down;
    assign act_mode  = p_mode;
    assign act_start = p_start & ~p_mode;
    assign act_up    = p_up    & ~p_mode & ~p_start;
    assign act_down  = p_down  & ~p_mode & ~p_start & ~p_up;

    state_e state_q, state_d;
    bcd2_t  pill_q, pill_d, bot_q, bot_d;
    logic   is_work_q, en_work_q, en_set_q, set_q, blink_q;

    always_comb begin
        state_d = state_q;
        pill_d  = pill_q;
        bot_d   = bot_q;
        case (state_q)
            ST_IDLE: begin
                if (act_mode)       state_d = ST_SET_PILL;
                else if (act_start) state_d = ST_CLEAR;
            end
            ST_SET_PILL: begin
                if (act_mode)       state_d = ST_SET_BOT;
                else if (act_up)    pill_d  = bcd2_inc_skip0(pill_q);
                else if (act_down)  pill_d  = bcd2_dec_skip0(pill_q);
            end
            ST_SET_BOT: begin
                if (act_mode)       state_d = ST_IDLE;
                else if (act_up)    bot_d   = bcd2_inc_skip0(bot_q);
                else if (act_down)  bot_d   = bcd2_dec_skip0(bot_q);
            end
            ST_CLEAR:               state_d = ST_RUN;
            ST_RUN: begin
                // Batch completion beats a concurrent pause request.
                if (allFull)        state_d = ST_DONE;
                else if (act_start) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (act_mode)       state_d = ST_IDLE;
                else if (act_start) state_d = ST_RUN;
            end
            ST_DONE: begin
                if (act_mode)       state_d = ST_IDLE;
                else if (act_start) state_d = ST_CLEAR;
            end
            default:                state_d = ST_IDLE;
        endcase
    end

    // Controls are decoded from the next state so they line up with state_o.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            pill_q    <= PILL_INIT;
            bot_q     <= BOT_INIT;
            is_work_q <= 1'b0;
            en_work_q <= 1'b0;
            en_set_q  <= 1'b0;
            set_q     <= 1'b1;
            blink_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pill_q  <= pill_d;
            bot_q   <= bot_d;
            case (state_d)
                ST_SET_PILL, ST_SET_BOT: begin
                    {is_work_q, en_work_q, en_set_q, set_q} <= 4'b0011;
                    blink_q <= 1'b1;
                end
                ST_CLEAR: begin
                    {is_work_q, en_work_q, en_set_q, set_q} <= 4'b0110;
                    blink_q <= 1'b0;
                end
                ST_RUN, ST_DONE: begin
                    // DONE keeps isWork so allFull stays latched downstream.
                    {is_work_q, en_work_q, en_set_q, set_q} <= 4'b1001;
                    blink_q <= 1'b0;
                end
                ST_PAUSE: begin
                    {is_work_q, en_work_q, en_set_q, set_q} <= 4'b1101;
                    blink_q <= 1'b0;
                end
                default: begin
                    {is_work_q, en_work_q, en_set_q, set_q} <= 4'b0001;
                    blink_q <= 1'b0;
                end
            endcase
        end
    end

    assign maxH       = pill_q.h;
    assign maxL       = pill_q.l;
    assign bot_maxH   = bot_q.h;
    assign bot_maxL   = bot_q.l;
    assign isWork     = is_work_q;
    assign EN_work    = en_work_q;
    assign EN_set     = en_set_q;
    assign set        = set_q;
    assign state_o    = state_q;
    assign edit_blink = blink_q;

endmodule

// File: tb/tb_bottle_setup_ctrl.sv
module tb_bottle_setup_ctrl;
    localparam int DEB = 20;
    localparam int HOLD = DEB + 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
    logic       allFull = 1'b0;
    logic [3:0] maxL, maxH, bot_maxL, bot_maxH;
    logic       isWork, EN_work, EN_set, set, edit_blink;
    logic [2:0] state_o;

    bottle_setup_ctrl #(.DEB_CYCLES(DEB)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
        .allFull(allFull),
        .maxL(maxL), .maxH(maxH), .bot_maxL(bot_maxL), .bot_maxH(bot_maxH),
        .isWork(isWork), .EN_work(EN_work), .EN_set(EN_set), .set(set),
        .state_o(state_o), .edit_blink(edit_blink)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: limits as plain integers 1..99, state as display code.
    int m_st   = 0;
    int m_pill = 12;
    int m_bot  = 5;

    function automatic int lim_inc(input int v);
        int r;
        r = v + 1;
        if (r > 99) r = 1;
        if (r % 10 == 0) r = r + 1;
        return r;
    endfunction

    function automatic int lim_dec(input int v);
        int r;
        r = v - 1;
        if (r < 1) r = 99;
        if (r % 10 == 0) r = r - 1;
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [3:0] exp_ctrl(input int st);
        case (st)
            1, 2:    return 4'b0011;
            3:       return 4'b0110;
            4, 6:    return 4'b1001;
            5:       return 4'b1101;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic model_press(input bit m, input bit s, input bit u, input bit d);
        if (m) begin
            case (m_st)
                0: m_st = 1;
                1: m_st = 2;
                2, 5, 6: m_st = 0;
                default: ;
            endcase
        end else if (s) begin
            case (m_st)
                0, 5, 6: m_st = 4;   // CLEAR is transient, settles in RUN
                4: m_st = 5;
                default: ;
            endcase
        end else if (u) begin
            if (m_st == 1) m_pill = lim_inc(m_pill);
            if (m_st == 2) m_bot  = lim_inc(m_bot);
        end else if (d) begin
            if (m_st == 1) m_pill = lim_dec(m_pill);
            if (m_st == 2) m_bot  = lim_dec(m_bot);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 8'(state_o), 8'(m_st));
        chk({tag, ".pill"},  {maxH, maxL}, to_bcd(m_pill));
        chk({tag, ".bot"},   {bot_maxH, bot_maxL}, to_bcd(m_bot));
        chk({tag, ".ctrl"},  8'({isWork, EN_work, EN_set, set}), 8'(exp_ctrl(m_st)));
        chk({tag, ".blink"}, 8'(edit_blink), 8'((m_st == 1 || m_st == 2) ? 1 : 0));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input bit m, input bit s, input bit u, input bit d);
        {btn_mode, btn_start, btn_up, btn_down} = {m, s, u, d};
        tick(HOLD);
        {btn_mode, btn_start, btn_up, btn_down} = 4'b0;
        tick(HOLD);
        model_press(m, s, u, d);
    endtask

    initial begin
        int nclr;
        int guard;
        // 1: reset
        tick(3);
        check_all("reset_held");
        RST_N = 1'b1;
        tick(3);
        check_all("reset_rel");

        // 2: enter SET_PILL, up x8 skips 20, then down
        press(1, 0, 0, 0);
        check_all("to_set_pill");
        for (int i = 0; i < 8; i++) press(0, 0, 1, 0);
        chk("pill_21", {maxH, maxL}, 8'h21);
        check_all("up8");
        press(0, 0, 0, 1);
        chk("pill_19", {maxH, maxL}, 8'h19);

        // 3: walk down to 01, wrap both ways
        guard = 0;
        while (m_pill != 1 && guard < 40) begin
            press(0, 0, 0, 1);
            guard++;
        end
        check_all("pill_01");
        press(0, 0, 0, 1);
        chk("pill_wrap99", {maxH, maxL}, 8'h99);
        press(0, 0, 1, 0);
        chk("pill_wrap01", {maxH, maxL}, 8'h01);
        press(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) press(0, 0, 1, 0);
        chk("bot_11", {bot_maxH, bot_maxL}, 8'h11);
        check_all("set_bot");
        press(1, 0, 0, 0);
        check_all("back_idle");

        // 4: start -> exactly one CLEAR cycle -> RUN -> PAUSE -> RUN
        nclr = 0;
        btn_start = 1'b1;
        for (int i = 0; i < HOLD; i++) begin
            @(negedge CLK);
            if (state_o == 3'd3) begin
                nclr++;
                chk("clear_ctrl", 8'({isWork, EN_work, EN_set, set}), 8'h06);
            end
        end
        chk("clear_once", 8'(nclr), 8'd1);
        btn_start = 1'b0;
        tick(HOLD);
        model_press(0, 1, 0, 0);
        check_all("run");
        press(0, 1, 0, 0);
        check_all("pause");
        press(0, 1, 0, 0);
        check_all("resume");

        // 5: allFull -> DONE next cycle, then mode -> IDLE
        allFull = 1'b1;
        tick(1);
        m_st = 6;
        check_all("done");
        allFull = 1'b0;
        press(1, 0, 0, 0);
        check_all("done_abort");

        // 6: filtering
        press(1, 0, 0, 0);
        btn_up = 1'b1;
        tick(10);
        btn_up = 1'b0;
        tick(HOLD);
        check_all("glitch");
        press(1, 0, 1, 0);
        check_all("mode_beats_up");
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        check_all("run_pre_rst");
        #2 RST_N = 1'b0;
        #1;
        m_st = 0; m_pill = 12; m_bot = 5;
        check_all("rst_mid_run");
        tick(2);
        RST_N = 1'b1;
        tick(2);

        // random phase: random button sets (priority) and allFull in RUN
        for (int it = 0; it < 40; it++) begin
            if (m_st == 4 && $urandom_range(0, 2) == 0) begin
                allFull = 1'b1;
                tick(2);
                allFull = 1'b0;
                m_st = 6;
                tick(1);
            end else begin
                logic [3:0] msk;
                msk = 4'($urandom_range(1, 15));
                press(msk[3], msk[2], msk[1], msk[0]);
            end
            check_all($sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
